count4_down_timer: RTL
======================

COUNT4_DOWN_TIMER -- requirements
Module: count4_down_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter AUTO_RELOAD, default 0; 1 selects periodic reload at terminal count, 0 selects one-shot.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port load  input  1  capture load_val into count and reload register.
REQ-006 SHALL have port load_val  input  WIDTH  start value for the countdown.
REQ-007 SHALL have port en  input  1  decrement enable while running.
REQ-008 SHALL have port count  output  WIDTH  current counter value, registered.
REQ-009 SHALL have port busy  output  1  high while the FSM is in RUN.
REQ-010 SHALL have port done  output  1  registered one-cycle pulse following a terminal decrement.
REQ-011 SHALL have port tc  output  1  combinational, high when count == 0.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL, on load=1 in any state, set count=load_val and reload register=load_val at the next edge.
REQ-014 SHALL, on load=1 with load_val != 0, enter RUN; with load_val == 0, enter IDLE and not pulse done.
REQ-015 SHALL give load priority over en when both are high in the same cycle; that cycle does not decrement.
REQ-016 SHALL, in RUN with en=1 and count > 1, decrement count by 1 per cycle.
REQ-017 SHALL, in RUN with en=0, hold count and state.
REQ-018 SHALL, in RUN with en=1 and count == 1 and AUTO_RELOAD=0, set count=0, enter DONE, and assert done for exactly one cycle.
REQ-019 SHALL, in RUN with en=1 and count == 1 and AUTO_RELOAD=1, set count=reload register, remain in RUN, and assert done for exactly one cycle.
REQ-020 SHALL leave DONE for IDLE after one cycle unconditionally unless load=1; load=1 takes REQ-013/014.
REQ-021 SHALL, in IDLE and DONE, ignore en and hold count.
REQ-022 SHALL never wrap count below 0; underflow is unreachable by construction.
REQ-023 SHALL drive busy=1 exactly when state == RUN.
REQ-024 SHALL assert done only on the cycle after a terminal decrement; done=0 at all other times.
REQ-025 SHALL, with load=1 arriving in the same cycle as a terminal decrement, apply load and suppress done.

Reset
REQ-026 SHALL, when rst_n=0 at a rising clk edge, set count=0, reload register=0, state=IDLE, done=0, busy=0.
REQ-027 SHALL give reset priority over load and en.
REQ-028 SHALL abort a running countdown on reset mid-operation with no done pulse.
REQ-029 SHALL drive tc=1 after reset because count=0.

Verification
REQ-030 One-shot count: AUTO_RELOAD=0, load 4'd3, en=1 held -> count 3,2,1,0 on successive cycles; done high one cycle with count=0; busy falls with done; then IDLE.
REQ-031 Enable gating: load 4'd5, en toggles 1,0,0,1 -> count 5,4,4,4,3; busy stays 1.
REQ-032 Auto-reload: AUTO_RELOAD=1, load 4'd2, en=1 for 6 cycles -> count 2,1,2,1,2,1; done pulses every second cycle; busy stays 1.
REQ-033 Load priority: in RUN at count=1, assert load=1 with load_val=4'd9 and en=1 -> count=9, no done pulse, state RUN.
REQ-034 Zero load and max value: load 4'd0 -> IDLE, tc=1, no done; load 4'd15 with en=1 -> done after exactly 15 enabled cycles.
REQ-035 Reset mid-run: load 4'd7, 3 enabled cycles, then rst_n=0 for 1 cycle -> count=0, busy=0, done=0; en alone afterward does not change count.

Source files
------------

// File: rtl/count4_down_timer.sv
// Loadable down-counter timer with IDLE/RUN/DONE control, one-shot or
// periodic auto-reload at terminal count, and a registered done pulse.
module count4_down_timer #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // Terminal decrement: the next enabled step would take count to zero.
    function automatic logic is_terminal(input logic [WIDTH-1:0] c);
        return (c <= WIDTH'(1));
    endfunction

    assign tc = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            reload_reg <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // A load overrides any decrement, including a terminal one,
                // so done stays low on this edge.
                count      <= load_val;
                reload_reg <= load_val;
                if (load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (en) begin
                            if (!is_terminal(count)) begin
                                count <= count - WIDTH'(1);
                            end else if (AUTO_RELOAD != 0) begin
                                count <= reload_reg;
                                done  <= 1'b1;
                            end else begin
                                count <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
